// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory with a request/ready front end.
// Byte-enable writes, a 1- or 2-cycle registered read pipeline, an optional
// write response (merged new word or pre-write word) and a clear sequencer
// that zeroes every location after reset.
module data_memory_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter int WR_RESP        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                wen,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ready,
    output logic                busy,
    output logic                rvalid,
    output logic [DATA_W-1:0]   data_out
);
    localparam int BE_W    = DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic CLEAR_EN    = (CLEAR_ON_RESET != 0);
    localparam logic WR_RESP_EN  = (WR_RESP != 0);
    localparam logic WR_RESP_NEW = (WR_RESP == 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RST_STATE = CLEAR_EN ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0] ram [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    logic              acc_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] old_p0;
    logic [DATA_W-1:0] new_p0;
    logic [DATA_W-1:0] dat_p0;

    // Replace the bytes of old_w selected by en with the bytes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   en
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // ---- stage p0: access accepted on this edge, response word selected ----
    // The RAM read sees every write committed on earlier edges, so a read
    // right after a write to the same address returns the written data.
    assign acc_p0 = req & ready;
    assign old_p0 = ram[addr];
    assign new_p0 = merge_bytes(old_p0, data_in, be);
    assign vld_p0 = acc_p0 & (~wen | WR_RESP_EN);
    assign dat_p0 = (wen & WR_RESP_NEW) ? new_p0 : old_p0;

    // Control FSM: clear sequencer after reset, then one access per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
            busy    <= CLEAR_EN;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST_ADDR) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port: the clear sequencer owns it while clearing; otherwise
    // accepted writes store the byte-merged word (be=0 rewrites the old word).
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[clr_cnt] <= '0;
        end else if (acc_p0 && wen) begin
            ram[addr] <= new_p0;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // ---- stage p1: response register drives the outputs ----
            // Response register; data_out holds between pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid   <= 1'b0;
                    data_out <= '0;
                end else begin
                    rvalid <= vld_p0;
                    if (vld_p0) data_out <= dat_p0;
                end
            end
        end else begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] dat_p1;

            // ---- stage p1: response in flight; reset drops it ----
            // Pipeline valid and output stage; reset discards in-flight reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1   <= 1'b0;
                    rvalid   <= 1'b0;
                    data_out <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    rvalid <= vld_p1;
                    if (vld_p1) data_out <= dat_p1;
                end
            end

            // Pipeline data; qualified by vld_p1 so it needs no reset.
            always_ff @(posedge clk) begin
                if (vld_p0) dat_p1 <= dat_p0;
            end
        end
    endgenerate

endmodule
